// File: rtl/vc_writeback_buffer_if.sv
// vc_writeback_buffer_if: victim-cache enqueue, forwarding read and pmem drain signals
interface vc_writeback_buffer_if #(parameter int LINE_W = 128, parameter int LADDR_W = 12);
  logic               wb_write;
  logic [LADDR_W-1:0] wb_address;
  logic [LINE_W-1:0]  wb_data;
  logic               wb_ack;
  logic               rd_req;
  logic [LADDR_W-1:0] rd_address;
  logic               rd_hit;
  logic [LINE_W-1:0]  rd_data;
  logic               pmem_busy_in;
  logic               pmem_resp;
  logic               pmem_write;
  logic [15:0]        pmem_address;
  logic [LINE_W-1:0]  pmem_wdata;
  logic               wb_busy;
  logic               full;
  logic               empty;
  modport master (
    output wb_write, wb_address, wb_data, rd_req, rd_address, pmem_busy_in, pmem_resp,
    input  wb_ack, rd_hit, rd_data, pmem_write, pmem_address, pmem_wdata, wb_busy, full, empty
  );
  modport slave (
    input  wb_write, wb_address, wb_data, rd_req, rd_address, pmem_busy_in, pmem_resp,
    output wb_ack, rd_hit, rd_data, pmem_write, pmem_address, pmem_wdata, wb_busy, full, empty
  );
endinterface

// File: rtl/vc_writeback_buffer.sv
// vc_writeback_buffer: coalescing line FIFO between victim cache and pmem with read forwarding
module vc_writeback_buffer #(
  parameter int DEPTH   = 4,
  parameter int LINE_W  = 128,
  parameter int LADDR_W = 12
) (
  input logic clk,
  input logic rst,
  vc_writeback_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0, WRITE = 1'b1;
  logic [DEPTH-1:0]   valid;
  logic [LADDR_W-1:0] addr [DEPTH];
  logic [LINE_W-1:0]  data [DEPTH];
  logic [PW-1:0]      head, tail, cidx, ridx;
  logic [PW:0]        count;
  logic [0:0]         state;
  logic               coal, alloc, pop, hit;
  logic [LINE_W-1:0]  rdat;
  // the head being drained is never a coalesce target so in-flight write data stays stable
  always_comb begin
    coal = 1'b0;
    cidx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.wb_write && valid[i] && addr[i] == bus.wb_address && !(state == WRITE && PW'(i) == head)) begin
        coal = 1'b1;
        cidx = PW'(i);
      end
  end
  // walk oldest to youngest so the youngest match wins
  always_comb begin
    hit = 1'b0;
    rdat = '0;
    ridx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ridx = head + PW'(k);
      if (valid[ridx] && addr[ridx] == bus.rd_address) begin
        hit = 1'b1;
        rdat = data[ridx];
      end
    end
  end
  assign alloc            = bus.wb_write & ~coal & ~bus.full;
  assign pop              = (state == WRITE) & bus.pmem_resp;
  assign bus.wb_ack       = coal | alloc;
  assign bus.rd_hit       = bus.rd_req & hit;
  assign bus.rd_data      = bus.rd_hit ? rdat : '0;
  assign bus.full         = count == (PW+1)'(DEPTH);
  assign bus.empty        = count == '0;
  assign bus.pmem_write   = state == WRITE;
  assign bus.wb_busy      = state == WRITE;
  assign bus.pmem_address = 16'({addr[head], 4'b0});
  assign bus.pmem_wdata   = data[head];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + (PW+1)'(alloc) - (PW+1)'(pop);
      state <= pop ? IDLE : (state == IDLE && count != '0 && !bus.pmem_busy_in) ? WRITE : state;
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr[tail] <= bus.wb_address;
      data[tail] <= bus.wb_data;
    end
    if (coal) data[cidx] <= bus.wb_data;
  end
endmodule

// File: tb/tb_vc_writeback_buffer.sv
// tb_vc_writeback_buffer: table-driven vectors plus directed multi-cycle sequences
module tb_vc_writeback_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  vc_writeback_buffer_if bus ();
  vc_writeback_buffer dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic         w;
    logic [11:0]  wa;
    logic [127:0] wd;
    logic         rq;
    logic [11:0]  ra;
    logic         bz;
    logic         rs;
    logic         e_ack;
    logic         e_hit;
    logic [127:0] e_rd;
    logic         e_pw;
    logic [15:0]  e_pa;
    logic [127:0] e_pd;
    logic         e_full;
    logic         e_empty;
  } vec_t;
  vec_t tbl[$];
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] D1 = 128'h1;
  task automatic add(input logic w, input logic [11:0] wa, input logic [127:0] wd, input logic rq,
                     input logic [11:0] ra, input logic bz, input logic rs, input logic e_ack,
                     input logic e_hit, input logic [127:0] e_rd, input logic e_pw, input logic [15:0] e_pa,
                     input logic [127:0] e_pd, input logic e_full, input logic e_empty);
    vec_t v;
    v = '{w, wa, wd, rq, ra, bz, rs, e_ack, e_hit, e_rd, e_pw, e_pa, e_pd, e_full, e_empty};
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] d(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16{b}};
  endfunction
  task automatic wait_pw;
    for (int n = 0; n < 20 && !bus.pmem_write; n++) step;
    chk("pw_wait", bus.pmem_write, 1);
  endtask
  task automatic drain(input logic [11:0] a, input logic [127:0] dd);
    wait_pw;
    chk("drain_addr", bus.pmem_address, {a, 4'h0});
    chk("drain_data", bus.pmem_wdata, dd);
    step;
    step;
    chk("drain_hold", bus.pmem_address, {a, 4'h0});
    bus.pmem_resp = 1'b1;
    #1;
    step;
    bus.pmem_resp = 1'b0;
    #1;
    chk("idle_gap", bus.pmem_write, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.wb_write = 0; bus.wb_address = '0; bus.wb_data = '0; bus.rd_req = 0; bus.rd_address = '0;
    bus.pmem_busy_in = 0; bus.pmem_resp = 0;
    //  w  wa      wd   rq ra      bz rs  ack hit rd  pw pa        pd  full empty
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  0, 16'h0,    0,  0, 1);
    add(1, 12'h012, A5, 0, 12'h0,   0, 0,  1, 0,  0,  0, 16'h0,    0,  0, 1);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  0, 16'h0,    0,  0, 0);
    add(0, 12'h0,   0,  1, 12'h012, 0, 0,  0, 1,  A5, 1, 16'h0120, A5, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  1, 16'h0120, A5, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  1, 16'h0120, A5, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  1, 16'h0120, A5, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 1,  0, 0,  0,  1, 16'h0120, A5, 0, 0);
    add(0, 12'h0,   0,  1, 12'h7FF, 0, 0,  0, 0,  0,  0, 16'h0,    0,  0, 1);
    add(1, 12'h020, D1, 0, 12'h0,   1, 0,  1, 0,  0,  0, 16'h0,    0,  0, 1);
    add(0, 12'h0,   0,  0, 12'h0,   1, 0,  0, 0,  0,  0, 16'h0,    0,  0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   1, 0,  0, 0,  0,  0, 16'h0,    0,  0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  0, 16'h0,    0,  0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   1, 0,  0, 0,  0,  1, 16'h0200, D1, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   1, 1,  0, 0,  0,  1, 16'h0200, D1, 0, 0);
    add(0, 12'h0,   0,  0, 12'h0,   0, 0,  0, 0,  0,  0, 16'h0,    0,  0, 1);
    step;
    step;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.wb_write = tbl[i].w; bus.wb_address = tbl[i].wa; bus.wb_data = tbl[i].wd;
      bus.rd_req = tbl[i].rq; bus.rd_address = tbl[i].ra;
      bus.pmem_busy_in = tbl[i].bz; bus.pmem_resp = tbl[i].rs;
      #1;
      chk($sformatf("v%0d_ack", i), bus.wb_ack, tbl[i].e_ack);
      chk($sformatf("v%0d_hit", i), bus.rd_hit, tbl[i].e_hit);
      chk($sformatf("v%0d_rdata", i), bus.rd_data, tbl[i].e_rd);
      chk($sformatf("v%0d_pwrite", i), bus.pmem_write, tbl[i].e_pw);
      chk($sformatf("v%0d_wbbusy", i), bus.wb_busy, tbl[i].e_pw);
      chk($sformatf("v%0d_full", i), bus.full, tbl[i].e_full);
      chk($sformatf("v%0d_empty", i), bus.empty, tbl[i].e_empty);
      if (tbl[i].e_pw) begin
        chk($sformatf("v%0d_paddr", i), bus.pmem_address, tbl[i].e_pa);
        chk($sformatf("v%0d_pdata", i), bus.pmem_wdata, tbl[i].e_pd);
      end
      step;
    end
    bus.wb_write = 0; bus.rd_req = 0; bus.pmem_resp = 0;
    bus.pmem_busy_in = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.wb_write = 1; bus.wb_address = 12'(i); bus.wb_data = d(i);
      #1;
      chk("fill_ack", bus.wb_ack, 1);
      step;
    end
    bus.wb_address = 12'h005; bus.wb_data = d(5);
    #1;
    chk("full_flag", bus.full, 1);
    chk("full_reject", bus.wb_ack, 0);
    step;
    bus.wb_address = 12'h003; bus.wb_data = d(8'h33);
    #1;
    chk("coalesce_ack", bus.wb_ack, 1);
    step;
    bus.wb_write = 0; bus.rd_req = 1; bus.rd_address = 12'h003;
    #1;
    chk("coalesce_count", dut.count, 4);
    chk("coalesce_rd", bus.rd_data, d(8'h33));
    bus.rd_req = 0;
    bus.pmem_busy_in = 0;
    wait_pw;
    chk("fpp_addr", bus.pmem_address, 16'h0010);
    chk("fpp_data", bus.pmem_wdata, d(1));
    bus.wb_write = 1; bus.wb_address = 12'h006; bus.wb_data = d(6); bus.pmem_resp = 1;
    #1;
    chk("fpp_ack", bus.wb_ack, 0);
    step;
    bus.wb_write = 0; bus.pmem_resp = 0;
    #1;
    chk("fpp_count", dut.count, 3);
    chk("fpp_gap", bus.pmem_write, 0);
    drain(12'h002, d(2));
    drain(12'h003, d(8'h33));
    drain(12'h004, d(4));
    chk("order_empty", bus.empty, 1);
    bus.wb_write = 1; bus.wb_address = 12'h040; bus.wb_data = d(8'h40);
    #1;
    step;
    bus.wb_write = 0;
    wait_pw;
    chk("dup_head_addr", bus.pmem_address, 16'h0400);
    bus.wb_write = 1; bus.wb_data = d(8'hBB);
    #1;
    chk("dup_alloc_ack", bus.wb_ack, 1);
    step;
    bus.wb_write = 0; bus.rd_req = 1; bus.rd_address = 12'h040;
    #1;
    chk("dup_count", dut.count, 2);
    chk("dup_hit", bus.rd_hit, 1);
    chk("dup_youngest", bus.rd_data, d(8'hBB));
    chk("dup_stable", bus.pmem_wdata, d(8'h40));
    bus.rd_req = 0; bus.pmem_resp = 1;
    #1;
    step;
    bus.pmem_resp = 0;
    #1;
    chk("dup_gap", bus.pmem_write, 0);
    drain(12'h040, d(8'hBB));
    for (int i = 0; i < 10; i++) begin
      bus.wb_write = 1; bus.wb_address = 12'(12'h100 + i); bus.wb_data = d(i + 16);
      #1;
      chk("wrap_ack", bus.wb_ack, 1);
      step;
      bus.wb_write = 0;
      #1;
      chk("wrap_count1", dut.count, 1);
      drain(12'(12'h100 + i), d(i + 16));
      chk("wrap_count0", dut.count, 0);
    end
    bus.wb_write = 1; bus.wb_address = 12'h055; bus.wb_data = d(8'h55);
    #1;
    step;
    bus.wb_write = 0;
    wait_pw;
    rst = 1;
    step;
    rst = 0;
    #1;
    chk("rst_pwrite", bus.pmem_write, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_wbbusy", bus.wb_busy, 0);
    bus.pmem_resp = 1;
    #1;
    step;
    bus.pmem_resp = 0;
    step;
    chk("late_resp_count", dut.count, 0);
    chk("late_resp_empty", bus.empty, 1);
    chk("late_resp_full", bus.full, 0);
    chk("late_resp_pw", bus.pmem_write, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_writeback_buffer.md
Name: vc_writeback_buffer

Overview:
- Write-back buffer directly downstream of the victim cache.
- Accepts dirty 128-bit lines evicted by the victim cache (wb_write / wb_address / wb_data) into a small FIFO.
- Drains them to physical memory whenever the L2→pmem path is idle, so evictions never stall on DRAM latency.
- Forwards buffered data to line reads issued toward pmem, which preserves coherence while lines sit in the buffer.

Parameters:
- DEPTH, 4, number of line entries; must be a power of two ≥ 2.
- LINE_W, 128, line width in bits.
- LADDR_W, 12, line-address width; the pmem byte address is {line_addr, 4'b0}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_write  in  1  victim cache requests enqueue of a dirty line; held until wb_ack.
- wb_address  in  LADDR_W  line address of the evicted line.
- wb_data  in  LINE_W  evicted line data.
- wb_ack  out  1  combinational; line accepted this cycle.
- rd_req  in  1  line read about to go to pmem (L2 miss path).
- rd_address  in  LADDR_W  line address of that read.
- rd_hit  out  1  combinational; buffer holds rd_address.
- rd_data  out  LINE_W  combinational; youngest matching entry's data, 0 when no hit.
- pmem_busy_in  in  1  other master currently owns pmem.
- pmem_resp  in  1  pmem completed the current write.
- pmem_write  out  1  registered; write request to pmem.
- pmem_address  out  16  {head line_addr, 4'b0}.
- pmem_wdata  out  LINE_W  head entry data.
- wb_busy  out  1  high while the drain FSM is in WRITE; arbiter blocks other masters.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH entries {valid, addr, data}; head/tail pointers wrap modulo DEPTH; count has width clog2(DEPTH)+1.
- Reset (sync, rst=1 at an edge):
  - all valid bits cleared; head = tail = count = 0; FSM returns to IDLE.
  - pmem_write = 0, wb_busy = 0, full = 0, empty = 1.
  - Reset mid-drain abandons the write: pmem_write is 0 from the next cycle, buffer contents are discarded, and a late pmem_resp is ignored.
- Enqueue and coalescing:
  - Coalesce case: wb_address matches a valid entry that is not the head currently being drained. The data is overwritten in place, no slot is allocated, and wb_ack=1 even if full.
  - Allocate case: otherwise, wb_ack = wb_write & ~full. On the edge the entry is written at tail, tail++ and count++.
  - A match only on the draining head allocates a new entry (or waits if full), so the in-flight write data stays stable.
- Drain FSM, two states:
  - IDLE → WRITE when ~empty & ~pmem_busy_in; pmem_write is registered high on entry.
  - WRITE: pmem_write=1 and pmem_address/pmem_wdata are driven from head, stable until pmem_resp.
  - On pmem_resp the head is cleared, head++, count-- and the FSM returns to IDLE.
  - There is always one IDLE cycle between consecutive writes so the arbiter can switch masters.
  - pmem_busy_in is sampled only in IDLE and never aborts a write in progress.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count unchanged. Full plus pop plus push in one cycle is legal; wb_ack uses the pre-edge full, so it stays 0.
  - Coalesce into an entry in the same cycle it is popped cannot occur, because the head is excluded from coalescing while in WRITE.
- Forwarding:
  - rd_hit/rd_data reflect pre-edge contents only; a same-cycle enqueue of the same address is not forwarded.
  - Youngest match wins, i.e. a new entry beats the draining head with the same address.
- Latency: enqueue to first pmem_write assertion is 1 cycle minimum (empty buffer, pmem idle).

Test Plan:
- Reset, then wb_write addr 0x012, data 0xA5..A5 → wb_ack=1 same cycle; next cycle empty=0. With pmem_busy_in=0, pmem_write=1 one cycle later with pmem_address=0x0120 and data 0xA5..; pmem_resp after 5 cycles → empty=1 and pmem_write=0 the next cycle.
- pmem_busy_in=1, 4 writes to addresses 0x001..0x004 → full=1; a 5th write to 0x005 gets wb_ack=0 and is held. A 5th write to 0x003 with new data instead coalesces (wb_ack=1, count stays 4). Release busy → drain order 0x001..0x004, and the 0x003 write carries the new data.
- Entry 0x040 draining; wb_write 0x040 with data B → new entry allocated. rd_req 0x040 → rd_hit=1, rd_data=B. After both drain, pmem sees the old data first, then B.
- rd_req 0x7FF with the buffer empty → rd_hit=0, rd_data=0.
- Pointer wrap: 10 single-line enqueue/drain cycles with DEPTH=4 → the addresses written to pmem exactly match enqueue order, and count never exceeds 1.
- rst asserted while in WRITE → next cycle pmem_write=0, empty=1, wb_busy=0; a pmem_resp arriving after reset causes no pop and no underflow (count stays 0).
